timer_bank_ctrl: RTL and testbench
==================================

TIMER_BANK_CTRL -- requirements
Module: timer_bank_ctrl

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 3, number of timer-bank words controlled.
REQ-002 SHALL have parameter TIMER_WIDTH, default 20, count field width (bits TIMER_WIDTH-1:0 of the timer word).
REQ-003 SHALL have port clk  input  1  sole clock.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start_req  input  NUM_TIMERS  per-timer start request, level, held until ack.
REQ-006 SHALL have port stop_req  input  NUM_TIMERS  per-timer stop request, level, held until ack.
REQ-007 SHALL have port load_value  input  NUM_TIMERS*TIMER_WIDTH  start count for timer i at slice i.
REQ-008 SHALL have port poll_en  input  1  enables expiry polling.
REQ-009 SHALL have port req_ack  output  NUM_TIMERS  one-cycle pulse when the request for timer i is written.
REQ-010 SHALL have port expired  output  NUM_TIMERS  one-cycle pulse when timer i has been found expired.
REQ-011 SHALL have port running  output  NUM_TIMERS  shadow of the active bit last written to timer i.
REQ-012 SHALL have ports avm_address (out 3), avm_read (out 1), avm_write (out 1), avm_writedata (out 32), avm_readdata (in 32): an AVMM host for the timer bank, timer i at address i.

Function
REQ-013 SHALL use FSM states IDLE, WRITE, READ, CHECK, CLEAR.
REQ-014 A timer is pending when start_req[i] or stop_req[i] is high and req_ack[i] is not asserted in that cycle.
REQ-015 In IDLE with any pending timer, SHALL select one by round-robin starting at wr_ptr, latch it, and enter WRITE.
REQ-016 In WRITE, SHALL drive avm_write=1 and avm_address=i for exactly one cycle, pulse req_ack[i] in the same cycle, set wr_ptr=i+1 (mod NUM_TIMERS), and return to IDLE.
REQ-017 The write data SHALL be bit28=1 with bits TIMER_WIDTH-1:0 = load_value slice i for a start; the write data SHALL be all zeros for a stop; all other bits SHALL be 0.
REQ-018 If start_req[i] and stop_req[i] are both high, stop SHALL win, a single ack SHALL cover both requests, and running[i] SHALL become 0.
REQ-019 running[i] SHALL update on the WRITE cycle to the written bit28.
REQ-020 In IDLE with no pending timer and poll_en=1, SHALL enter READ for poll_ptr.
REQ-021 In READ, SHALL assert avm_read=1 with avm_address=poll_ptr for one cycle and capture avm_readdata in that same cycle (the timer bank returns read data combinationally).
REQ-022 In CHECK, a timer is expired if captured bit28=1 and the count field is 0; if expired, SHALL pulse expired[poll_ptr] and go to CLEAR, otherwise SHALL go to IDLE.
REQ-023 On leaving CHECK, poll_ptr SHALL advance by 1, wrapping from NUM_TIMERS-1 to 0.
REQ-024 In CLEAR, SHALL write all zeros to the expired timer and clear running[i], then return to IDLE, so that each expiry pulses exactly once.
REQ-025 Latency: a request seen in IDLE at cycle N SHALL be acked at N+1; a poll SHALL take 3 cycles, or 4 cycles with CLEAR.
REQ-026 A request arriving during READ, CHECK or CLEAR SHALL be served after the return to IDLE, and requests SHALL take priority over polling.
REQ-027 avm_read and avm_write SHALL never be high together, and SHALL be 0 outside READ and WRITE/CLEAR respectively.
REQ-028 A poll started before poll_en deasserts SHALL complete.

Reset
REQ-029 With resetn=0 at a clk edge, the FSM SHALL go to IDLE regardless of state, wr_ptr=0, poll_ptr=0, and running, req_ack, expired, avm_read, avm_write, avm_writedata and avm_address SHALL be 0 from the following cycle.
REQ-030 Reset mid-transaction SHALL abandon the transaction without any ack or expiry pulse.

Verification
REQ-031 Start timer1 with load 5, bank model ticking -> write addr1 data 0x10000005, req_ack[1] at N+1, running[1]=1; after 5 ticks a poll sees 0x10000000 -> expired[1] pulses once, CLEAR writes 0, running[1]=0.
REQ-032 start_req=3'b111 held high -> writes in order 0,1,2, with one ack per timer and no back-to-back ack on the same timer.
REQ-033 start_req[2] and stop_req[2] high together -> a single write of 0x00000000 to addr2 with req_ack[2] pulsed.
REQ-034 poll_en=1 with no requests -> reads cycle through addr 0,1,2,0 every 3 cycles; inactive or nonzero timers give no expired pulse.
REQ-035 resetn low during CHECK with an expired timer captured -> no expired pulse, all outputs 0, first poll after reset reads addr0.
REQ-036 stop_req[0] raised during READ -> the poll completes, and the write to addr0 follows in the cycle after IDLE is reached.

Source files
------------

// File: rtl/timer_bank_if.sv
// Avalon-MM host bus between timer_bank_ctrl and the timer bank.
// Timer i sits at address i, and the bank returns read data combinationally.
interface timer_bank_if;
   logic [2:0]  avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata,
      input  avm_readdata
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata,
      output avm_readdata
   );
endinterface

// File: rtl/timer_bank_ctrl.sv
// Serves start/stop requests to a bank of hardware timers over AVMM.
// When no request is waiting, it polls the timers round-robin for expiry.
module timer_bank_ctrl #(
   parameter int NUM_TIMERS  = 3,
   parameter int TIMER_WIDTH = 20
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic [NUM_TIMERS-1:0]             start_req,
   input  logic [NUM_TIMERS-1:0]             stop_req,
   input  logic [NUM_TIMERS*TIMER_WIDTH-1:0] load_value,
   input  logic                              poll_en,
   output logic [NUM_TIMERS-1:0]             req_ack,
   output logic [NUM_TIMERS-1:0]             expired,
   output logic [NUM_TIMERS-1:0]             running,
   timer_bank_if.master                      bus
);

   localparam int IDX_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

   typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, CLEAR} state_t;

   state_t                 state, state_next;
   logic [IDX_W-1:0]       wr_ptr, poll_ptr, sel_idx, clr_idx, pick_idx;
   logic                   pick_found;
   logic [31:0]            sel_data, pick_data;
   logic                   rd_active;
   logic [TIMER_WIDTH-1:0] rd_count;
   logic [NUM_TIMERS-1:0]  pending;
   logic                   hit;
   int                     cand;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      if (int'(idx) == NUM_TIMERS - 1)
         return '0;
      return idx + IDX_W'(1);
   endfunction

   // Pulses are gated by resetn so that a reset abandons a transaction without an ack or expiry.
   always_comb begin
      req_ack = '0;
      if (state == WRITE)
         req_ack[sel_idx] = resetn;
   end

   assign pending = (start_req | stop_req) & ~req_ack;
   assign hit     = rd_active && (rd_count == '0);

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int k = 0; k < NUM_TIMERS; k++) begin
         cand = int'(wr_ptr) + k;
         if (cand >= NUM_TIMERS)
            cand = cand - NUM_TIMERS;
         if (!pick_found && pending[cand]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   // Stop wins over start: a stop writes all zeros, which also drops the active bit.
   always_comb begin
      pick_data = '0;
      if (!stop_req[pick_idx]) begin
         pick_data[28]            = 1'b1;
         pick_data[TIMER_WIDTH-1:0] = load_value[int'(pick_idx)*TIMER_WIDTH +: TIMER_WIDTH];
      end
   end

   always_comb begin
      state_next        = state;
      expired           = '0;
      bus.avm_read      = 1'b0;
      bus.avm_write     = 1'b0;
      bus.avm_address   = '0;
      bus.avm_writedata = '0;
      case (state)
         IDLE: begin
            if (pick_found)
               state_next = WRITE;
            else if (poll_en)
               state_next = READ;
         end
         WRITE: begin
            bus.avm_write     = 1'b1;
            bus.avm_address   = 3'(sel_idx);
            bus.avm_writedata = sel_data;
            state_next        = IDLE;
         end
         READ: begin
            bus.avm_read    = 1'b1;
            bus.avm_address = 3'(poll_ptr);
            state_next      = CHECK;
         end
         CHECK: begin
            if (hit) begin
               expired[poll_ptr] = resetn;
               state_next        = CLEAR;
            end else begin
               state_next = IDLE;
            end
         end
         CLEAR: begin
            bus.avm_write   = 1'b1;
            bus.avm_address = 3'(clr_idx);
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         poll_ptr  <= '0;
         running   <= '0;
         sel_idx   <= '0;
         sel_data  <= '0;
         clr_idx   <= '0;
         rd_active <= 1'b0;
         rd_count  <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  sel_idx  <= pick_idx;
                  sel_data <= pick_data;
               end
            end
            WRITE: begin
               running[sel_idx] <= sel_data[28];
               wr_ptr           <= next_idx(sel_idx);
            end
            READ: begin
               rd_active <= bus.avm_readdata[28];
               rd_count  <= bus.avm_readdata[TIMER_WIDTH-1:0];
            end
            CHECK: begin
               clr_idx  <= poll_ptr;
               poll_ptr <= next_idx(poll_ptr);
            end
            CLEAR: running[clr_idx] <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_bank_ctrl.sv
// Directed bench for timer_bank_ctrl with a ticking timer-bank model and
// a scoreboard of expected bus transactions.
module tb_timer_bank_ctrl;

   localparam int NT = 3;
   localparam int TW = 20;

   typedef struct {
      logic        is_write;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [2:0]  ack;
   } bus_evt_t;

   logic              clk = 1'b0;
   logic              resetn;
   logic [NT-1:0]     start_req, stop_req;
   logic [NT*TW-1:0]  load_value;
   logic              poll_en;
   logic [NT-1:0]     req_ack, expired, running;
   logic              tick_en;
   logic [31:0]       bank [8] = '{default: 32'h0};

   bus_evt_t          exp_q[$];
   bus_evt_t          mon_e;
   int                read_cyc[$];
   int                ack_cnt [NT];
   int                exp_cnt [NT];
   int                cyc = 0;
   int                n_checks = 0;
   int                n_fail = 0;
   int                lat;
   int                saved;

   timer_bank_if bus ();

   timer_bank_ctrl #(.NUM_TIMERS(NT), .TIMER_WIDTH(TW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start_req  (start_req),
      .stop_req   (stop_req),
      .load_value (load_value),
      .poll_en    (poll_en),
      .req_ack    (req_ack),
      .expired    (expired),
      .running    (running),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Timer bank: a write replaces the word, otherwise active timers count down to zero.
   assign bus.avm_readdata = bank[bus.avm_address];

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (bus.avm_write && bus.avm_address == 3'(i))
            bank[i] <= bus.avm_writedata;
         else if (tick_en && bank[i][28] && bank[i][TW-1:0] != '0)
            bank[i] <= bank[i] - 32'd1;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic push_write(input logic [2:0] a, input logic [31:0] d, input logic [2:0] ack);
      exp_q.push_back('{1'b1, a, d, ack});
   endtask

   task automatic push_read(input logic [2:0] a);
      exp_q.push_back('{1'b0, a, 32'h0, 3'b000});
   endtask

   // Scoreboard side: every bus transaction must match the next queued expectation.
   always @(negedge clk) begin
      for (int i = 0; i < NT; i++) begin
         if (req_ack[i]) ack_cnt[i]++;
         if (expired[i]) exp_cnt[i]++;
      end
      if (bus.avm_read || bus.avm_write) begin
         check_output("rd_wr_exclusive", 32'(bus.avm_read & bus.avm_write), 32'h0);
         if (bus.avm_read) read_cyc.push_back(cyc);
         check_output("bus_event_expected", 32'(exp_q.size() != 0), 32'h1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_output("bus_kind_is_write", 32'(bus.avm_write), 32'(mon_e.is_write));
            check_output("bus_addr", 32'(bus.avm_address), 32'(mon_e.addr));
            if (mon_e.is_write)
               check_output("bus_wdata", bus.avm_writedata, mon_e.data);
            check_output("bus_req_ack", 32'(req_ack), 32'(mon_e.ack));
         end
      end else begin
         check_output("ack_without_write", 32'(req_ack), 32'h0);
      end
   end

   task automatic apply_stimulus(input logic [2:0] st, input logic [2:0] sp, output int latency);
      int          c0;
      int          n;
      logic [2:0]  remaining;
      c0        = cyc;
      latency   = -1;
      n         = 0;
      start_req = start_req | st;
      stop_req  = stop_req | sp;
      remaining = st | sp;
      while (remaining != 3'b000 && n < 30) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < NT; i++) begin
            if (req_ack[i]) begin
               if (latency < 0) latency = cyc - c0;
               start_req[i] = 1'b0;
               stop_req[i]  = 1'b0;
               remaining[i] = 1'b0;
            end
         end
      end
      check_output("request_served", 32'(remaining), 32'h0);
   endtask

   task automatic wait_queue_empty(input int limit, input string tag);
      int n;
      n = 0;
      while (n < limit) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) break;
         n++;
      end
      check_output(tag, 32'(exp_q.size()), 32'h0);
   endtask

   task automatic wait_read(input int limit, input string tag);
      int   n;
      logic found;
      n     = 0;
      found = 1'b0;
      while (n < limit && !found) begin
         @(negedge clk);
         if (bus.avm_read) found = 1'b1;
         n++;
      end
      #1;
      check_output(tag, 32'(found), 32'h1);
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_running"},   32'(running), 32'h0);
      check_output({tag, "_req_ack"},   32'(req_ack), 32'h0);
      check_output({tag, "_expired"},   32'(expired), 32'h0);
      check_output({tag, "_avm_read"},  32'(bus.avm_read), 32'h0);
      check_output({tag, "_avm_write"}, 32'(bus.avm_write), 32'h0);
      check_output({tag, "_avm_wdata"}, bus.avm_writedata, 32'h0);
      check_output({tag, "_avm_addr"},  32'(bus.avm_address), 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetn     = 1'b0;
      start_req  = '0;
      stop_req   = '0;
      load_value = '0;
      poll_en    = 1'b0;
      tick_en    = 1'b0;
      for (int i = 0; i < NT; i++) begin
         ack_cnt[i] = 0;
         exp_cnt[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      resetn = 1'b1;

      // Start timer1 with load 5, let it count down, then poll it to expiry.
      @(posedge clk); #1;
      load_value[1*TW +: TW] = 20'd5;
      push_write(3'd1, 32'h1000_0005, 3'b010);
      apply_stimulus(3'b010, 3'b000, lat);
      check_output("start1_ack_latency", 32'(lat), 32'd1);
      @(posedge clk); #1;
      check_output("start1_running", 32'(running), 32'b010);
      tick_en = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      tick_en = 1'b0;
      push_read(3'd0);
      push_read(3'd1);
      push_write(3'd1, 32'h0, 3'b000);
      poll_en = 1'b1;
      wait_queue_empty(40, "timer1_poll_done");
      poll_en = 1'b0;
      @(posedge clk); #1;
      check_output("timer1_cleared_running", 32'(running), 32'b000);
      check_output("timer1_expired_once", 32'(exp_cnt[1]), 32'd1);
      check_output("timer0_not_expired", 32'(exp_cnt[0]), 32'd0);

      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;

      // All three starts held together: served 0,1,2 with one ack each.
      @(posedge clk); #1;
      load_value = '0;
      load_value[0*TW +: TW] = 20'h00111;
      load_value[1*TW +: TW] = 20'h00222;
      load_value[2*TW +: TW] = 20'h00003;
      for (int i = 0; i < NT; i++) ack_cnt[i] = 0;
      push_write(3'd0, 32'h1000_0111, 3'b001);
      push_write(3'd1, 32'h1000_0222, 3'b010);
      push_write(3'd2, 32'h1000_0003, 3'b100);
      apply_stimulus(3'b111, 3'b000, lat);
      check_output("all_start_first_latency", 32'(lat), 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < NT; i++)
         check_output($sformatf("all_start_ack_count_%0d", i), 32'(ack_cnt[i]), 32'd1);
      check_output("all_start_running", 32'(running), 32'b111);

      // Start and stop together on timer2: the stop wins with a single ack.
      push_write(3'd2, 32'h0, 3'b100);
      apply_stimulus(3'b100, 3'b100, lat);
      check_output("start_stop2_latency", 32'(lat), 32'd1);
      @(posedge clk); #1;
      check_output("start_stop2_ack_count", 32'(ack_cnt[2]), 32'd2);
      check_output("start_stop2_running", 32'(running), 32'b011);

      // Plain polling: addresses 0,1,2,0 three cycles apart, nothing expires.
      read_cyc.delete();
      saved = exp_cnt[0] + exp_cnt[1] + exp_cnt[2];
      push_read(3'd0);
      push_read(3'd1);
      push_read(3'd2);
      push_read(3'd0);
      poll_en = 1'b1;
      wait_queue_empty(40, "poll_cycle_done");
      poll_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("poll_read_count", 32'(read_cyc.size()), 32'd4);
      if (read_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++)
            check_output($sformatf("poll_period_%0d", i), 32'(read_cyc[i] - read_cyc[i-1]), 32'd3);
      end
      check_output("poll_no_expiry", 32'(exp_cnt[0] + exp_cnt[1] + exp_cnt[2]), 32'(saved));

      // Stop on timer0 raised mid-READ: the poll finishes, then the write follows.
      @(posedge clk); #1;
      push_read(3'd1);
      push_write(3'd0, 32'h0, 3'b001);
      poll_en = 1'b1;
      wait_read(20, "stop_during_read_seen");
      poll_en = 1'b0;
      apply_stimulus(3'b000, 3'b001, lat);
      check_output("stop_during_read_latency", 32'(lat), 32'd3);
      @(posedge clk); #1;
      check_output("stop_during_read_running", 32'(running), 32'b010);

      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;

      // Reset in CHECK with an expired timer captured: no pulse, poll restarts at addr0.
      @(posedge clk); #1;
      load_value[0*TW +: TW] = 20'h0;
      push_write(3'd0, 32'h1000_0000, 3'b001);
      apply_stimulus(3'b001, 3'b000, lat);
      check_output("expired0_start_latency", 32'(lat), 32'd1);
      @(posedge clk); #1;
      saved = exp_cnt[0];
      push_read(3'd0);
      poll_en = 1'b1;
      wait_read(20, "poll_before_reset_seen");
      @(posedge clk); #1;
      resetn = 1'b0;
      @(negedge clk);
      check_output("reset_in_check_expired", 32'(expired), 32'h0);
      @(negedge clk);
      check_all_zero("reset_in_check");
      check_output("reset_in_check_no_pulse", 32'(exp_cnt[0]), 32'(saved));
      push_read(3'd0);
      push_write(3'd0, 32'h0, 3'b000);
      @(posedge clk); #1;
      resetn = 1'b1;
      wait_queue_empty(40, "after_reset_poll_done");
      poll_en = 1'b0;
      @(posedge clk); #1;
      check_output("after_reset_expired_once", 32'(exp_cnt[0]), 32'(saved + 1));
      check_output("after_reset_running", 32'(running), 32'b000);
      repeat (3) @(posedge clk);
      #1;
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
